// File: rtl/fifo36_demux4.sv
// Packet-level 1-to-4 demultiplexer for fifo36 streams (SOF=bit32, EOF=bit33).
// Whole packets go to the port chosen by sel on the first beat; en=0 packets are discarded.
module fifo36_demux4 #(
    parameter int unsigned WIDTH     = 36,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [1:0]           sel,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 src_rdy_i,
    output logic                 dst_rdy_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [3:0]           src_rdy_o,
    input  logic [3:0]           dst_rdy_i,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned EOF_BIT = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t     state;
    logic       out_valid;
    logic [1:0] port_r;
    logic [1:0] sel_r;

    logic take_c;
    logic in_fire_c;
    logic eof_c;

    // Output register drains when its selected port accepts; a new beat may load in the same cycle.
    assign take_c    = out_valid & dst_rdy_i[port_r];
    assign dst_rdy_o = reset_n & ~clear & ((state == DROP) | ~out_valid | take_c);
    assign in_fire_c = src_rdy_i & dst_rdy_o;
    assign eof_c     = data_i[EOF_BIT];
    assign src_rdy_o = out_valid ? 4'(4'b0001 << port_r) : 4'b0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            port_r     <= 2'd0;
            sel_r      <= 2'd0;
            data_o     <= '0;
            drop_count <= '0;
        end else if (clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            if (take_c) begin
                out_valid <= 1'b0;
            end
            if (in_fire_c) begin
                case (state)
                    IDLE: begin
                        // Any beat seen in IDLE starts a packet, SOF or not.
                        sel_r <= sel;
                        if (en) begin
                            out_valid <= 1'b1;
                            port_r    <= sel;
                            data_o    <= data_i;
                            state     <= eof_c ? IDLE : ROUTE;
                        end else begin
                            if (drop_count != '1) begin
                                drop_count <= drop_count + CNT_WIDTH'(1);
                            end
                            state <= eof_c ? IDLE : DROP;
                        end
                    end
                    ROUTE: begin
                        out_valid <= 1'b1;
                        port_r    <= sel_r;
                        data_o    <= data_i;
                        state     <= eof_c ? IDLE : ROUTE;
                    end
                    DROP: begin
                        state <= eof_c ? IDLE : DROP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
